// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier
// sequencer that borrows an external combinational ALU, one add per clock.
// While idle, the ALU is granted to an external requester through a pass-through.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   start_i        multiply request, sampled only in IDLE
//   mcand_i        multiplicand, captured on accepted start
//   mplier_i       multiplier, captured on accepted start
//   busy_o         high in RUN and DONE
//   done_o         one-cycle pulse, product valid
//   product_o      {hi, lo}; held until the next accepted start
//   ext_a_i/ext_b_i/ext_oper_i  external requester ALU inputs
//   ext_gnt_o      external requester owns the ALU
//   alu_a_o/alu_b_o/alu_oper_o  to ALU
//   alu_result_i/alu_cout_i     from ALU
module alu_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    input  logic [WIDTH-1:0]   ext_a_i,
    input  logic [WIDTH-1:0]   ext_b_i,
    input  logic [2:0]         ext_oper_i,
    output logic               ext_gnt_o,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    output logic [2:0]         alu_oper_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    input  logic               alu_cout_i
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [2:0] OpAdd = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        ext_gnt_o  = 1'b0;
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_oper_o = 3'b000;

        unique case (state_q)
            StIdle: begin
                busy_o     = 1'b0;
                ext_gnt_o  = 1'b1;
                alu_a_o    = ext_a_i;
                alu_b_o    = ext_b_i;
                alu_oper_o = ext_oper_i;
                if (start_i) begin
                    mcand_d = mcand_i;
                    hi_d    = '0;
                    lo_d    = mplier_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                alu_a_o    = hi_q;
                alu_b_o    = lo_q[0] ? mcand_q : '0;
                alu_oper_o = OpAdd;
                // Sum and carry shift right into {hi, lo}; multiplier bits fall off lo[0].
                {hi_d, lo_d} = {alu_cout_i, alu_result_i, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign product_o = {hi_q, lo_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam int unsigned W = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   ext_a;
    logic [W-1:0]   ext_b;
    logic [2:0]     ext_oper;
    logic           ext_gnt;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_oper;
    logic [W-1:0]   alu_result;
    logic           alu_cout;

    int total;
    int bad;

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .mcand_i     (mcand),
        .mplier_i    (mplier),
        .busy_o      (busy),
        .done_o      (done),
        .product_o   (product),
        .ext_a_i     (ext_a),
        .ext_b_i     (ext_b),
        .ext_oper_i  (ext_oper),
        .ext_gnt_o   (ext_gnt),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_oper_o  (alu_oper),
        .alu_result_i(alu_result),
        .alu_cout_i  (alu_cout)
    );

    // Behavioural stand-in for the external combinational ALU.
    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_oper)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b110:  begin
                alu_result = alu_a - alu_b;
                alu_cout   = (alu_a >= alu_b);
            end
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    // Full multiply: accept edge, operands scrambled afterwards, then 36 cycles observed.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input string nm);
        int nb, nd, di;
        logic bz;
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = ~a;
        mplier = ~b;
        nb = 0; nd = 0; di = -1; bz = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                di = i;
                chk({nm, " product@done"}, product, exp);
            end
            if (i < 32 && alu_b !== '0) bz = 1'b0;
        end
        chk({nm, " done count"}, 64'(nd), 64'd1);
        chk({nm, " done cycle"}, 64'(di), 64'd32);
        chk({nm, " busy cycles"}, 64'(nb), 64'd33);
        chk({nm, " product held"}, product, exp);
        if (b == '0) chk({nm, " alu_b zero in RUN"}, 64'(bz), 64'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int nd, di;
        logic seen_b34;
        total = 0;
        bad   = 0;
        vecs[0] = '{32'd3, 32'd5, 64'd15};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'h12345678, 32'h0, 64'h0};
        vecs[3] = '{32'h0, 32'h80000000, 64'h0};
        vecs[4] = '{32'd1, 32'd1, 64'd1};
        vecs[5] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
        vecs[6] = '{32'hDEADBEEF, 32'd2, 64'h00000001BD5B7DDE};
        vecs[7] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};

        reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        ext_a = 32'd10; ext_b = 32'd4; ext_oper = 3'b110;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset product", product, 64'd0);
        chk("reset ext_gnt", 64'(ext_gnt), 64'd1);
        reset = 1'b0;

        // External pass-through while idle.
        @(negedge clk);
        chk("idle alu_oper", 64'(alu_oper), 64'd6);
        chk("idle alu_a", 64'(alu_a), 64'd10);
        chk("idle ext_gnt", 64'(ext_gnt), 64'd1);
        chk("idle alu_result", 64'(alu_result), 64'd6);

        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // During RUN the external requester is locked out.
        @(negedge clk);
        mcand = 32'd5; mplier = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ext_oper = 3'b001; ext_a = 32'hAAAA5555;
        chk("run ext_gnt", 64'(ext_gnt), 64'd0);
        chk("run alu_oper", 64'(alu_oper), 64'd2);
        repeat (40) @(negedge clk);
        chk("run 5*5", product, 64'd25);

        // start held high across a full multiply: no queueing during RUN.
        @(negedge clk);
        mcand = 32'd7; mplier = 32'd9; start = 1'b1;
        @(posedge clk);
        nd = 0; di = -1; seen_b34 = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done) begin nd++; di = i; end
            if (i == 32) chk("held product", product, 64'd63);
            if (i == 33) chk("held idle gap busy", 64'(busy), 64'd0);
            if (i == 34) seen_b34 = busy;
        end
        chk("held done count", 64'(nd), 64'd1);
        chk("held done cycle", 64'(di), 64'd32);
        chk("held re-accept", 64'(seen_b34), 64'd1);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("held 2nd product", product, 64'd63);
            end
        end
        chk("held 2nd done count", 64'(nd), 64'd1);

        // Abort mid-RUN with reset.
        @(negedge clk);
        mcand = 32'd100; mplier = 32'd200; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort product", product, 64'd0);
        chk("abort ext_gnt", 64'(ext_gnt), 64'd1);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort no done", 64'(nd), 64'd0);
        run_mul(32'd6, 32'd7, 64'd42, "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 32x32 -> 64 multiplier sequencer built around the existing combinational 32-bit ALU, which stays outside this block. It drives the ALU's operand and operation inputs for one shift-add iteration per clock and returns a 64-bit product with a busy/done handshake. While idle it grants the ALU to an external requester through a pass-through port, so one ALU instance serves both plain ALU operations and multiplication.

## Interface
- WIDTH, 32, operand width; equals ALU width and iteration count.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- mcand  in  WIDTH  multiplicand, captured on accepted start.
- mplier  in  WIDTH  multiplier, captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result; held until next accepted start.
- ext_a, ext_b  in  WIDTH  external requester operands.
- ext_oper  in  3  external requester operation code.
- ext_gnt  out  1  high when the external requester owns the ALU (= !busy).
- alu_a, alu_b  out  WIDTH  to ALU operands.
- alu_oper  out  3  to ALU operation select.
- alu_result  in  WIDTH  from ALU result.
- alu_cout  in  1  from ALU carry out.

## Operation
- Registers: mcand_r, hi (WIDTH), lo (WIDTH), cnt (5 bits for WIDTH=32), state.
- States: IDLE, RUN, DONE.
- IDLE:
  - ALU mux selects ext_a/ext_b/ext_oper; ext_gnt=1.
  - On start=1: mcand_r<=mcand, hi<=0, lo<=mplier, cnt<=0, go RUN.
- RUN:
  - ALU mux drives alu_a=hi, alu_b = lo[0] ? mcand_r : 0, alu_oper=3'b010 (ADD, carry-in 0); ext_gnt=0.
  - Each edge: {hi,lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]}; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: go DONE.
  - With alu_b=0, alu_cout is 0, so a skipped add shifts in 0.
- DONE:
  - done=1 and product={hi,lo}; ALU mux as in IDLE-less default (alu_a=0, alu_b=0, alu_oper=3'b000); ext_gnt=0.
  - Next edge: go IDLE.
- product is a continuous view of {hi,lo}. It is stable from DONE until the next accepted start, and intermediate during RUN.
- Arithmetic is unsigned; no overflow is possible in 2*WIDTH. The ALU overflow and zero outputs are unused.
- start in RUN or DONE is ignored and not queued. start and reset in the same cycle: reset wins.
- mcand/mplier changes after the accept edge have no effect.

## Timing
- Reset (edge with reset=1, any state including mid-RUN): state=IDLE, hi=0, lo=0, cnt=0, mcand_r=0.
  - Outputs after reset: busy=0, done=0, product=0, ext_gnt=1, ALU ports follow ext_*.
  - An aborted multiply produces no done.
- Latency: start sampled at edge E0; RUN spans edges E1..E32; done=1 in the cycle after E32; IDLE again after E33. The next start can be accepted at E34, so throughput is one multiply per 34 cycles.
- busy rises in the cycle after E0 and falls in the cycle after E33.
- The ALU is combinational with gate delays of about 40 ns worst case through the ripple carry. The clock period must exceed the ALU path plus mux delay; the bench uses a period of at least 200 ns.
- ALU ownership switches only on clock edges, so ext_* users must sample ext_gnt before relying on alu_result.

## Test plan
- Reset, then start with mcand=3, mplier=5 -> busy for 33 cycles; single done pulse 33 cycles after the accept edge; product=64'd15; returns to IDLE.
- mcand=32'hFFFFFFFF, mplier=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 (exercises alu_cout shift-in every iteration).
- mcand=32'h12345678, mplier=0 -> product=0; alu_b=0 in all 32 RUN cycles. Separately, mcand=0, mplier=32'h80000000 -> product=0.
- start held high across a full multiply of 7*9 -> product=63; exactly one done; the second multiply is accepted only at the edge after DONE, i.e. start is not queued during RUN.
- Assert reset at RUN cycle 10 of 100*200 -> next cycle busy=0, product=0, no done; a fresh multiply of 6*7 then yields 42.
- IDLE with ext_a=10, ext_b=4, ext_oper=3'b110 -> alu_oper=110, ext_gnt=1, alu_result=6. During RUN -> ext_gnt=0 and alu_oper=010 regardless of ext_*.
